// File: rtl/zion_basic_circuit_lib_rr_dff_arb.sv
// Round-robin arbiter feeding one shared registered output stage.
// Several valid/ready producers compete for a single output register.
// The register is loaded when it is empty or being drained in the same cycle.
// The rotating priority pointer advances past each winner, so under full
// demand every requester waits at most NUM_REQ-1 transfers.
module zion_basic_circuit_lib_rr_dff_arb #(
  parameter int                NUM_REQ  = 4,
  parameter int                WIDTH    = 32,
  parameter logic [WIDTH-1:0]  INI_DATA = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               iReqVld,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]    iReqDat,
  output logic [NUM_REQ-1:0]               oReqRdy,
  output logic                             oVld,
  output logic [WIDTH-1:0]                 oDat,
  output logic [$clog2(NUM_REQ)-1:0]       oSrc,
  input  logic                             iRdy
);

  localparam int               SW        = $clog2(NUM_REQ);
  localparam int               SW1       = SW + 1;
  localparam logic [SW:0]      NUM_REQ_W = SW1'(NUM_REQ);
  localparam logic [SW-1:0]    LAST_IDX  = SW'(NUM_REQ - 1);

  generate
    if (NUM_REQ < 2 || WIDTH < 1) begin : g_param_err
`ifdef CHECK_ERR_EXIT
      $fatal(1, "zion_basic_circuit_lib_rr_dff_arb: NUM_REQ must be >= 2 and WIDTH >= 1");
`else
      $error("zion_basic_circuit_lib_rr_dff_arb: NUM_REQ must be >= 2 and WIDTH >= 1");
`endif
    end
  endgenerate

  logic               vld_q, vld_d;
  logic [WIDTH-1:0]   dat_q, dat_d;
  logic [SW-1:0]      src_q, src_d;
  logic [SW-1:0]      ptr_q, ptr_d;

  logic               ld_s;
  logic               found_s;
  logic [SW-1:0]      win_s;
  logic               gnt_s;
  logic [SW-1:0]      ptr_nxt_s;
  logic [NUM_REQ-1:0] rdy_s;

  // Round-robin search: scan from ptr downward in priority so the entry closest to ptr wins.
  always_comb begin
    logic [SW:0] idx_v;
    win_s   = '0;
    idx_v   = '0;
    found_s = |iReqVld;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx_v = {1'b0, ptr_q} + SW1'(k);
      idx_v = (idx_v >= NUM_REQ_W) ? (idx_v - NUM_REQ_W) : idx_v;
      win_s = iReqVld[idx_v[SW-1:0]] ? idx_v[SW-1:0] : win_s;
    end
  end

  // Grant decode: one-hot ready to the winner when the register can accept; nothing while in reset.
  always_comb begin
    ld_s      = !vld_q || iRdy;
    gnt_s     = rst && ld_s && found_s;
    ptr_nxt_s = (win_s == LAST_IDX) ? '0 : (win_s + SW'(1));
    rdy_s     = '0;
    rdy_s[win_s] = gnt_s;
  end

  // Next-state for the output register and priority pointer.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    src_d = src_q;
    ptr_d = ptr_q;
    if (gnt_s) begin
      // Load (possibly replacing data being drained this same edge).
      vld_d = 1'b1;
      dat_d = iReqDat[win_s];
      src_d = win_s;
      ptr_d = ptr_nxt_s;
    end else if (iRdy) begin
      // Drained with nothing to refill; data and source are kept for observation.
      vld_d = 1'b0;
    end else begin
      // Stalled or idle-and-empty: hold everything.
      vld_d = vld_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= 1'b0;
      dat_q <= INI_DATA;
      src_q <= '0;
      ptr_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      src_q <= src_d;
      ptr_q <= ptr_d;
    end
  end

  assign oReqRdy = rdy_s;
  assign oVld    = vld_q;
  assign oDat    = dat_q;
  assign oSrc    = src_q;

endmodule

// File: tb/tb_zion_basic_circuit_lib_rr_dff_arb.sv
// Directed bench for the round-robin arbiter with registered output stage.
module tb_zion_basic_circuit_lib_rr_dff_arb;

  localparam int          N   = 4;
  localparam int          W   = 32;
  localparam logic [31:0] INI = 32'hA5A5_0000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_vld;
  logic [N-1:0][W-1:0]  req_dat;
  logic [N-1:0]         req_rdy;
  logic                 o_vld;
  logic [W-1:0]         o_dat;
  logic [1:0]           o_src;
  logic                 i_rdy;

  int errors = 0;
  int checks = 0;

  zion_basic_circuit_lib_rr_dff_arb #(
    .NUM_REQ  (N),
    .WIDTH    (W),
    .INI_DATA (INI)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .iReqVld (req_vld),
    .iReqDat (req_dat),
    .oReqRdy (req_rdy),
    .oVld    (o_vld),
    .oDat    (o_dat),
    .oSrc    (o_src),
    .iRdy    (i_rdy)
  );

  always #5 clk = ~clk;

  // Requester protocol monitor: a valid that was not granted must still be valid next edge.
  logic [N-1:0] pend_q = '0;
  always @(posedge clk) begin
    if (rst) begin
      assert ((req_vld & pend_q) == pend_q)
        else $error("protocol violation: valid dropped before transfer, pending=%b vld=%b", pend_q, req_vld);
    end
    pend_q <= rst ? (req_vld & ~req_rdy) : '0;
  end

  typedef struct {
    logic         rst;
    logic [3:0]   vld;
    logic         rdy;
    logic [3:0]   e_rdy;
    logic         e_vld;
    logic [31:0]  e_dat;
    logic [1:0]   e_src;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic rd);
    rst     = r;
    req_vld = v;
    i_rdy   = rd;
  endtask

  initial begin
    // rst, vld, rdy | exp ready, exp oVld, exp oDat, exp oSrc
    // Reset held with every requester valid.
    vecs[0]  = '{1'b0, 4'hF, 1'b1, 4'h0, 1'b0, INI,   2'd0};
    vecs[1]  = '{1'b0, 4'hF, 1'b1, 4'h0, 1'b0, INI,   2'd0};
    vecs[2]  = '{1'b0, 4'hF, 1'b1, 4'h0, 1'b0, INI,   2'd0};
    // First grant after reset goes to 0, then full rotation.
    vecs[3]  = '{1'b1, 4'hF, 1'b1, 4'h1, 1'b0, INI,   2'd0};
    vecs[4]  = '{1'b1, 4'hF, 1'b1, 4'h2, 1'b1, 32'd1, 2'd0};
    vecs[5]  = '{1'b1, 4'hF, 1'b1, 4'h4, 1'b1, 32'd2, 2'd1};
    vecs[6]  = '{1'b1, 4'hF, 1'b1, 4'h8, 1'b1, 32'd3, 2'd2};
    vecs[7]  = '{1'b1, 4'hF, 1'b1, 4'h1, 1'b1, 32'd4, 2'd3};
    vecs[8]  = '{1'b1, 4'hF, 1'b1, 4'h2, 1'b1, 32'd1, 2'd0};
    // Reset while full.
    vecs[9]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 32'd2, 2'd1};
    // Single transfer then drain to empty; data holds.
    vecs[10] = '{1'b1, 4'h1, 1'b1, 4'h1, 1'b0, INI,   2'd0};
    vecs[11] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 32'd1, 2'd0};
    vecs[12] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 32'd1, 2'd0};
    vecs[13] = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 32'd1, 2'd0};
    // Empty register accepts without iRdy; then stall, then resume with rotation.
    vecs[14] = '{1'b1, 4'h3, 1'b0, 4'h2, 1'b0, 32'd1, 2'd0};
    vecs[15] = '{1'b1, 4'h3, 1'b0, 4'h0, 1'b1, 32'd2, 2'd1};
    vecs[16] = '{1'b1, 4'h3, 1'b1, 4'h1, 1'b1, 32'd2, 2'd1};
    vecs[17] = '{1'b1, 4'h2, 1'b1, 4'h2, 1'b1, 32'd1, 2'd0};
    vecs[18] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 32'd2, 2'd1};
    vecs[19] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 32'd2, 2'd1};

    for (int i = 0; i < N; i++) req_dat[i] = 32'(i + 1);
    drive(1'b0, 4'hF, 1'b1);
    next_cycle();

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].rdy);
      @(negedge clk);
      check($sformatf("v%0d_rdy", i), {28'd0, req_rdy}, {28'd0, vecs[i].e_rdy});
      check($sformatf("v%0d_vld", i), {31'd0, o_vld},   {31'd0, vecs[i].e_vld});
      check($sformatf("v%0d_dat", i), o_dat,            vecs[i].e_dat);
      check($sformatf("v%0d_src", i), {30'd0, o_src},   {30'd0, vecs[i].e_src});
      next_cycle();
    end

    // Stall with a single requester holding.
    drive(1'b0, 4'h0, 1'b0);
    next_cycle();
    req_dat[2] = 32'h0000_003C;
    drive(1'b1, 4'h4, 1'b0);
    @(negedge clk);
    check("stall_first_rdy", {28'd0, req_rdy}, 32'h4);
    check("stall_first_vld", {31'd0, o_vld}, 32'h0);
    next_cycle();
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      check($sformatf("stall%0d_rdy", s), {28'd0, req_rdy}, 32'h0);
      check($sformatf("stall%0d_vld", s), {31'd0, o_vld}, 32'h1);
      check($sformatf("stall%0d_dat", s), o_dat, 32'h0000_003C);
      check($sformatf("stall%0d_src", s), {30'd0, o_src}, 32'd2);
      next_cycle();
    end
    i_rdy = 1'b1;
    @(negedge clk);
    check("resume_rdy", {28'd0, req_rdy}, 32'h4);
    check("resume_dat", o_dat, 32'h0000_003C);
    next_cycle();

    // Wrap and skip: ptr is 3 after the grant to requester 2.
    req_dat[1] = 32'h0000_0011;
    req_dat[3] = 32'h0000_0033;
    drive(1'b1, 4'hA, 1'b1);
    @(negedge clk);
    check("wrap_first_rdy", {28'd0, req_rdy}, 32'h8);
    check("resume_vld_held", {31'd0, o_vld}, 32'h1);
    check("resume_src", {30'd0, o_src}, 32'd2);
    next_cycle();
    req_vld = 4'h2;
    @(negedge clk);
    check("wrap_second_rdy", {28'd0, req_rdy}, 32'h2);
    check("wrap_dat3", o_dat, 32'h0000_0033);
    check("wrap_src3", {30'd0, o_src}, 32'd3);
    next_cycle();

    // Reset mid-stream while stalled with data held.
    req_dat[0] = 32'h0000_0099;
    drive(1'b1, 4'h1, 1'b0);
    @(negedge clk);
    check("mid_pre_rdy", {28'd0, req_rdy}, 32'h0);
    check("mid_pre_dat", o_dat, 32'h0000_0011);
    check("mid_pre_src", {30'd0, o_src}, 32'd1);
    next_cycle();
    drive(1'b0, 4'h1, 1'b0);
    @(negedge clk);
    check("mid_rst_rdy", {28'd0, req_rdy}, 32'h0);
    next_cycle();
    drive(1'b1, 4'hF, 1'b1);
    @(negedge clk);
    check("mid_post_vld", {31'd0, o_vld}, 32'h0);
    check("mid_post_dat", o_dat, INI);
    check("mid_post_src", {30'd0, o_src}, 32'd0);
    check("mid_post_ptr0", {28'd0, req_rdy}, 32'h1);
    next_cycle();
    drive(1'b1, 4'hE, 1'b0);
    @(negedge clk);
    check("mid_load_vld", {31'd0, o_vld}, 32'h1);
    check("mid_load_dat", o_dat, 32'h0000_0099);
    check("mid_load_rdy", {28'd0, req_rdy}, 32'h0);
    next_cycle();
    drive(1'b0, 4'h0, 1'b0);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
